// File: rtl/vscale_htif_pcr_arbiter.sv
// Round-robin arbiter sharing the CSR file's HTIF PCR port between N_REQ
// host-side requesters, one transaction outstanding at a time.
module vscale_htif_pcr_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned IDX_WIDTH  = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            in_req_valid,
  output logic [N_REQ-1:0]            in_req_ready,
  input  logic [N_REQ-1:0]            in_req_rw,
  input  logic [N_REQ*ADDR_WIDTH-1:0] in_req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] in_req_data,
  output logic [N_REQ-1:0]            in_resp_valid,
  input  logic [N_REQ-1:0]            in_resp_ready,
  output logic [DATA_WIDTH-1:0]       in_resp_data,
  output logic                        out_req_valid,
  input  logic                        out_req_ready,
  output logic                        out_req_rw,
  output logic [ADDR_WIDTH-1:0]       out_req_addr,
  output logic [DATA_WIDTH-1:0]       out_req_data,
  input  logic                        out_resp_valid,
  output logic                        out_resp_ready,
  input  logic [DATA_WIDTH-1:0]       out_resp_data,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0]  owner_q, owner_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [N_REQ-1:0]      valid_rot;
  logic                  found;
  logic [IDX_WIDTH-1:0]  offset;
  logic [IDX_WIDTH:0]    win_sum;
  logic [IDX_WIDTH-1:0]  winner;
  logic                  sel_rw;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [N_REQ-1:0]      owner_onehot;

  // Winner search: rotate the valid vector so rr_ptr sits at bit 0, take the
  // lowest set bit, then map the offset back to an absolute index mod N_REQ.
  always_comb begin
    valid_rot = N_REQ'({in_req_valid, in_req_valid} >> rr_ptr_q);
    found     = 1'b0;
    offset    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (valid_rot[k] && !found) begin
        found  = 1'b1;
        offset = IDX_WIDTH'(k);
      end
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
    if (win_sum >= (IDX_WIDTH+1)'(N_REQ)) begin
      win_sum = win_sum - (IDX_WIDTH+1)'(N_REQ);
    end
    winner   = win_sum[IDX_WIDTH-1:0];
    sel_rw   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (winner == IDX_WIDTH'(k)) begin
        sel_rw   = in_req_rw[k];
        sel_addr = in_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = in_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and outputs; every output is forced low while reset is held.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    rw_d           = rw_q;
    addr_d         = addr_q;
    data_d         = data_q;
    owner_onehot   = N_REQ'(1) << owner_q;
    in_req_ready   = '0;
    in_resp_valid  = '0;
    in_resp_data   = '0;
    out_req_valid  = 1'b0;
    out_resp_ready = 1'b0;
    out_req_rw     = rw_q;
    out_req_addr   = addr_q;
    out_req_data   = data_q;
    busy           = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (found) begin
          in_req_ready = N_REQ'(1) << winner;
          owner_d      = winner;
          rw_d         = sel_rw;
          addr_d       = sel_addr;
          data_d       = sel_data;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        out_req_valid = 1'b1;
        if (out_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        in_resp_valid  = owner_onehot & {N_REQ{out_resp_valid}};
        out_resp_ready = |(in_resp_ready & owner_onehot);
        in_resp_data   = out_resp_data;
        if (out_resp_valid && out_resp_ready) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == IDX_WIDTH'(N_REQ-1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      in_req_ready   = '0;
      in_resp_valid  = '0;
      in_resp_data   = '0;
      out_req_valid  = 1'b0;
      out_resp_ready = 1'b0;
      out_req_rw     = 1'b0;
      out_req_addr   = '0;
      out_req_data   = '0;
      busy           = 1'b0;
    end
  end

  // State, pointer and latched request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
module tb_vscale_htif_pcr_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    in_req_valid = '0;
  logic [N-1:0]    in_req_ready;
  logic [N-1:0]    in_req_rw = '0;
  logic [N*AW-1:0] in_req_addr = '0;
  logic [N*DW-1:0] in_req_data = '0;
  logic [N-1:0]    in_resp_valid;
  logic [N-1:0]    in_resp_ready = '0;
  logic [DW-1:0]   in_resp_data;
  logic            out_req_valid;
  logic            out_req_ready = 1'b0;
  logic            out_req_rw;
  logic [AW-1:0]   out_req_addr;
  logic [DW-1:0]   out_req_data;
  logic            out_resp_valid = 1'b0;
  logic            out_resp_ready;
  logic [DW-1:0]   out_resp_data = '0;
  logic            busy;

  vscale_htif_pcr_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDX_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready),
    .in_req_rw(in_req_rw), .in_req_addr(in_req_addr), .in_req_data(in_req_data),
    .in_resp_valid(in_resp_valid), .in_resp_ready(in_resp_ready),
    .in_resp_data(in_resp_data),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready),
    .out_req_rw(out_req_rw), .out_req_addr(out_req_addr), .out_req_data(out_req_data),
    .out_resp_valid(out_resp_valid), .out_resp_ready(out_resp_ready),
    .out_resp_data(out_resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one pending transaction record, a pointer,
  // and a log of grants and completions.
  bit            m_busy = 0;
  bit            m_issued = 0;
  int            m_owner = 0;
  int            m_ptr = 0;
  logic          m_rw = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_grants[$];
  int            m_done = 0;

  logic [N-1:0]  e_rdy, e_rv;
  logic          e_oqv, e_orr, e_busy, e_rw;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  always @(negedge clk) begin
    int w;
    int c;
    e_rdy = '0; e_rv = '0; e_oqv = 1'b0; e_orr = 1'b0; e_busy = 1'b0;
    e_rw = m_rw; e_addr = m_addr; e_data = m_data;
    w = -1;
    if (reset) begin
      e_rw = 1'b0; e_addr = '0; e_data = '0;
    end else if (!m_busy) begin
      for (int j = 0; j < N; j++) begin
        c = (m_ptr + j) % N;
        if (w < 0 && in_req_valid[c]) w = c;
      end
      if (w >= 0) e_rdy[w] = 1'b1;
    end else if (!m_issued) begin
      e_oqv = 1'b1; e_busy = 1'b1;
    end else begin
      e_busy = 1'b1;
      e_rv[m_owner] = out_resp_valid;
      e_orr = in_resp_ready[m_owner];
    end

    chk("in_req_ready", in_req_ready, e_rdy);
    chk("in_resp_valid", in_resp_valid, e_rv);
    chk("out_req_valid", out_req_valid, e_oqv);
    chk("out_resp_ready", out_resp_ready, e_orr);
    chk("busy", busy, e_busy);
    chk("out_req_rw", out_req_rw, e_rw);
    chk("out_req_addr", out_req_addr, e_addr);
    chk("out_req_data", out_req_data, e_data);
    if (e_rv != '0) chk("in_resp_data", in_resp_data, out_resp_data);

    if (reset) begin
      m_busy = 0; m_issued = 0; m_ptr = 0; m_owner = 0;
      m_rw = 1'b0; m_addr = '0; m_data = '0;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1; m_issued = 0; m_owner = w;
        m_rw = in_req_rw[w];
        m_addr = in_req_addr[w*AW +: AW];
        m_data = in_req_data[w*DW +: DW];
        m_grants.push_back(w);
      end
    end else if (!m_issued) begin
      if (out_req_ready) m_issued = 1;
    end else if (out_resp_valid && in_resp_ready[m_owner]) begin
      m_busy = 0;
      m_ptr = (m_owner + 1) % N;
      m_done++;
    end
  end

  int g_idx[$];
  int g_cyc[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic rw,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_req_valid[i] = v;
    in_req_rw[i] = rw;
    in_req_addr[i*AW +: AW] = a;
    in_req_data[i*DW +: DW] = d;
  endtask

  task automatic csr_auto();
    out_req_ready = 1'b1;
    out_resp_valid = 1'b1;
    in_resp_ready = '1;
  endtask

  // Run n cycles recording observed grants; requesters drop valid on grant
  // unless keep is set.
  task automatic run_auto(input int n, input bit keep);
    logic [N-1:0] hs;
    g_idx.delete();
    g_cyc.delete();
    for (int cy = 0; cy < n; cy++) begin
      at_neg();
      hs = in_req_valid & in_req_ready;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          g_idx.push_back(i);
          g_cyc.push_back(cy);
        end
      end
      out_resp_data = {$urandom, $urandom};
      step();
      if (!keep) in_req_valid = in_req_valid & ~hs;
    end
  endtask

  initial begin
    int base;
    int completions;
    logic [N-1:0] hs;

    step(); step();
    reset = 1'b0;
    at_neg();
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_req_ready, 0);
    chk("rst_addr", out_req_addr, 0);
    step();

    // Single read from requester 0.
    set_req(0, 1, 0, 12'h780, 0);
    at_neg(); chk("sr_grant", in_req_ready, 4'b0001);
    step();
    in_req_valid[0] = 1'b0; out_req_ready = 1'b1;
    at_neg(); chk("sr_issue_v", out_req_valid, 1); chk("sr_issue_addr", out_req_addr, 12'h780);
    step();
    out_req_ready = 1'b0; out_resp_valid = 1'b1; out_resp_data = 64'h1234; in_resp_ready = 4'b0001;
    at_neg(); chk("sr_resp_v", in_resp_valid, 4'b0001); chk("sr_resp_d", in_resp_data, 64'h1234);
    step();
    out_resp_valid = 1'b0; in_resp_ready = '0;
    at_neg(); chk("sr_busy_done", busy, 0);
    step();

    // Spurious response while idle.
    out_resp_valid = 1'b1; out_resp_data = 64'hBAD; in_resp_ready = '1;
    at_neg(); chk("spur_rv", in_resp_valid, 0); chk("spur_orr", out_resp_ready, 0);
    step();
    out_resp_valid = 1'b0; in_resp_ready = '0;

    // Simultaneous requests from reset.
    do_reset();
    set_req(0, 1, 1, 12'h780, 64'd5);
    set_req(1, 1, 0, 12'h781, 64'd0);
    csr_auto();
    base = m_grants.size();
    run_auto(8, 0);
    chk("sim_ngrants", g_idx.size(), 2);
    if (g_idx.size() == 2) begin
      chk("sim_g0_idx", g_idx[0], 0); chk("sim_g0_cyc", g_cyc[0], 0);
      chk("sim_g1_idx", g_idx[1], 1); chk("sim_g1_cyc", g_cyc[1], 3);
    end
    chk("sim_model_n", m_grants.size() - base, 2);
    if (m_grants.size() - base == 2) begin
      chk("sim_model_g0", m_grants[base], 0);
      chk("sim_model_g1", m_grants[base+1], 1);
    end
    set_req(0, 1, 0, 12'h782, 0);
    set_req(1, 1, 0, 12'h783, 0);
    run_auto(9, 0);
    chk("sim_next_n", g_idx.size(), 2);
    if (g_idx.size() == 2) begin
      chk("sim_next_idx", g_idx[0], 0); chk("sim_next_cyc", g_cyc[0], 0);
    end

    // Fairness with all four requesters valid continuously.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, i[0], AW'(12'h790 + i), DW'(100 + i));
    csr_auto();
    base = m_grants.size();
    run_auto(24, 1);
    in_req_valid = '0;
    chk("fair_n", g_idx.size(), 8);
    chk("fair_model_n", m_grants.size() - base, 8);
    for (int t = 0; t < 8; t++) begin
      if (t < g_idx.size()) begin
        chk("fair_idx", g_idx[t], t % 4);
        chk("fair_cyc", g_cyc[t], 3 * t);
      end
      if (base + t < m_grants.size()) chk("fair_model_idx", m_grants[base+t], t % 4);
    end

    // Backpressure on both CSR-side request and owner-side response.
    do_reset();
    out_req_ready = 1'b0; out_resp_valid = 1'b0; in_resp_ready = '0;
    set_req(2, 1, 1, 12'h7A0, 64'hDEAD_BEEF_0000_0002);
    at_neg(); chk("bp_grant", in_req_ready, 4'b0100);
    step();
    in_req_valid[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("bp_hold_v", out_req_valid, 1); chk("bp_hold_addr", out_req_addr, 12'h7A0);
      chk("bp_hold_data", out_req_data, 64'hDEAD_BEEF_0000_0002); chk("bp_hold_rw", out_req_rw, 1);
      step();
    end
    out_req_ready = 1'b1;
    at_neg(); chk("bp_accept_v", out_req_valid, 1);
    step();
    out_req_ready = 1'b0; out_resp_valid = 1'b1; out_resp_data = 64'h77; in_resp_ready = 4'b1011;
    completions = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) in_resp_ready = 4'b0100;
      at_neg();
      if (out_resp_valid && out_resp_ready) completions++;
      if (k < 2) begin
        chk("bp_orr_low", out_resp_ready, 0); chk("bp_rv", in_resp_valid, 4'b0100);
      end else if (k == 2) begin
        chk("bp_orr_high", out_resp_ready, 1);
      end
      step();
    end
    chk("bp_completions", completions, 1);
    out_resp_valid = 1'b0; in_resp_ready = '0;

    // Reset while a response is pending.
    do_reset();
    set_req(1, 1, 0, 12'h7B0, 0);
    out_req_ready = 1'b1;
    at_neg(); chk("rm_grant", in_req_ready, 4'b0010);
    step();
    in_req_valid[1] = 1'b0;
    at_neg();
    step();
    out_req_ready = 1'b0; out_resp_valid = 1'b1; in_resp_ready = '0;
    at_neg(); chk("rm_in_resp", in_resp_valid, 4'b0010);
    step();
    reset = 1'b1;
    at_neg();
    step();
    reset = 1'b0;
    at_neg();
    chk("rm_busy", busy, 0); chk("rm_rv", in_resp_valid, 0); chk("rm_orr", out_resp_ready, 0);
    step();
    set_req(1, 1, 1, 12'h7B1, 64'h42);
    csr_auto();
    run_auto(4, 0);
    chk("rm_regrant_n", g_idx.size(), 1);
    if (g_idx.size() == 1) begin
      chk("rm_regrant_idx", g_idx[0], 1); chk("rm_regrant_cyc", g_cyc[0], 0);
    end

    // Randomised traffic with protocol-respecting requesters.
    in_req_valid = '0;
    for (int cy = 0; cy < 3000; cy++) begin
      at_neg();
      hs = in_req_valid & in_req_ready;
      step();
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (hs[i]) in_req_valid[i] = 1'b0;
        if (!in_req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1, $urandom_range(0, 1) == 1, AW'($urandom), {$urandom, $urandom});
      end
      out_req_ready = ($urandom_range(0, 2) != 0);
      out_resp_valid = ($urandom_range(0, 2) != 0);
      out_resp_data = {$urandom, $urandom};
      in_resp_ready = N'($urandom);
    end
    reset = 1'b0;
    in_req_valid = '0;
    csr_auto();
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
